// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the Mini-SRC hardwired sequencer: opcodes, ALU functions,
// sequencer states, instruction classes and the bundle of Datapath strobes.
package cpu_ctrl_pkg;

    localparam int OPW    = 5;
    localparam int ALUOPW = 4;

    localparam logic [OPW-1:0] OP_LD   = 5'b00000;
    localparam logic [OPW-1:0] OP_ST   = 5'b00010;
    localparam logic [OPW-1:0] OP_ADD  = 5'b00011;
    localparam logic [OPW-1:0] OP_SUB  = 5'b00100;
    localparam logic [OPW-1:0] OP_AND  = 5'b00101;
    localparam logic [OPW-1:0] OP_OR   = 5'b00110;
    localparam logic [OPW-1:0] OP_ADDI = 5'b01100;
    localparam logic [OPW-1:0] OP_BR   = 5'b10010;
    localparam logic [OPW-1:0] OP_JR   = 5'b10011;
    localparam logic [OPW-1:0] OP_JAL  = 5'b10100;
    localparam logic [OPW-1:0] OP_IN   = 5'b10101;
    localparam logic [OPW-1:0] OP_OUT  = 5'b10110;
    localparam logic [OPW-1:0] OP_NOP  = 5'b11010;
    localparam logic [OPW-1:0] OP_HALT = 5'b11011;

    localparam logic [ALUOPW-1:0] ALU_PASS = 4'd0;
    localparam logic [ALUOPW-1:0] ALU_ADD  = 4'd1;
    localparam logic [ALUOPW-1:0] ALU_SUB  = 4'd2;
    localparam logic [ALUOPW-1:0] ALU_AND  = 4'd3;
    localparam logic [ALUOPW-1:0] ALU_OR   = 4'd4;

    typedef enum logic [3:0] {
        S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
    } state_e;

    typedef enum logic [3:0] {
        CL_NOP, CL_ALU, CL_ADDI, CL_LD, CL_ST, CL_BR, CL_JR, CL_JAL, CL_IN, CL_OUT, CL_HALT
    } class_e;

    typedef struct packed {
        logic run;
        logic pc_out, pc_in, inc_pc;
        logic mar_in, mdr_in, mdr_out, read, write;
        logic ir_in, y_in, zlow_in, zlow_out;
        logic gra, grb, grc, r_in, r_out, ba_out;
        logic c_out, con_in, jal_flag;
        logic in_port_out, out_port_in;
        logic [ALUOPW-1:0] alu_op;
    } ctl_t;

    // Final execute step of each class; the instruction boundary is the edge leaving it.
    function automatic state_e last_step(input class_e cls);
        case (cls)
            CL_ALU, CL_ADDI, CL_JAL: return S_T5;
            CL_LD, CL_ST:            return S_T7;
            CL_BR:                   return S_T6;
            default:                 return S_T3;
        endcase
    endfunction

endpackage

// File: rtl/cu_decode.sv
// Opcode decoder: maps IR[31:27] to an instruction class and the ALU function
// that class uses in its arithmetic step.
module cu_decode
    import cpu_ctrl_pkg::*;
(
    input  logic [OPW-1:0]    opcode_i,
    output class_e            cls_o,
    output logic [ALUOPW-1:0] alu_op_o
);

    always_comb begin
        cls_o    = CL_NOP;
        alu_op_o = ALU_PASS;
        case (opcode_i)
            OP_LD:   begin cls_o = CL_LD;   alu_op_o = ALU_ADD; end
            OP_ST:   begin cls_o = CL_ST;   alu_op_o = ALU_ADD; end
            OP_ADD:  begin cls_o = CL_ALU;  alu_op_o = ALU_ADD; end
            OP_SUB:  begin cls_o = CL_ALU;  alu_op_o = ALU_SUB; end
            OP_AND:  begin cls_o = CL_ALU;  alu_op_o = ALU_AND; end
            OP_OR:   begin cls_o = CL_ALU;  alu_op_o = ALU_OR;  end
            OP_ADDI: begin cls_o = CL_ADDI; alu_op_o = ALU_ADD; end
            OP_BR:   begin cls_o = CL_BR;   alu_op_o = ALU_ADD; end
            OP_JR:   cls_o = CL_JR;
            OP_JAL:  cls_o = CL_JAL;
            OP_IN:   cls_o = CL_IN;
            OP_OUT:  cls_o = CL_OUT;
            OP_HALT: cls_o = CL_HALT;
            default: cls_o = CL_NOP;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Hardwired Moore sequencer for the Mini-SRC: fetch T0..T2, class-specific execute
// T3..T7, halting on HALT or on Stop at an instruction boundary.
//   state | meaning
//   RST   | after clear, all strobes low, Run=0
//   T0-T2 | fetch: PC->MAR, memory read, MDR->IR
//   T3-T7 | execute steps of the latched class
//   HALT  | stopped, all strobes low, left only by clear
module control_unit
    import cpu_ctrl_pkg::*;
(
    input  logic        clock,
    input  logic        clear,
    input  logic [31:0] IR,
    input  logic        CON,
    input  logic        Stop,
    output logic        Run,
    output logic        PCout,
    output logic        PCin,
    output logic        IncPC,
    output logic        MARin,
    output logic        MDRin,
    output logic        MDRout,
    output logic        Read,
    output logic        Write,
    output logic        IRin,
    output logic        Yin,
    output logic        Zlowin,
    output logic        Zlowout,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        BAout,
    output logic        Cout,
    output logic        CONin,
    output logic        JAL_flag,
    output logic        InPortout,
    output logic        OutPortin,
    output logic [3:0]  alu_op
);

    state_e            state_q, state_d;
    class_e            cls_q, cls_d, dec_cls;
    logic [ALUOPW-1:0] alu_q, alu_d, dec_alu;
    ctl_t              ctl_q, ctl_d, ctl_o;
    logic              unused_ir;

    assign unused_ir = ^IR[31-OPW:0];

    cu_decode u_decode (
        .opcode_i (IR[31:32-OPW]),
        .cls_o    (dec_cls),
        .alu_op_o (dec_alu)
    );

    always_comb begin
        state_d = state_q;
        cls_d   = cls_q;
        alu_d   = alu_q;
        case (state_q)
            S_RST:  state_d = S_T0;
            S_T0:   state_d = S_T1;
            S_T1:   state_d = S_T2;
            S_T2: begin
                cls_d   = dec_cls;
                alu_d   = dec_alu;
                state_d = (dec_cls == CL_HALT) ? S_HALT : S_T3;
            end
            S_HALT: state_d = S_HALT;
            default: begin
                if (state_q == last_step(cls_q))
                    state_d = Stop ? S_HALT : S_T0;
                else
                    state_d = state_e'(state_q + 4'd1);
            end
        endcase
    end

    // Strobes are decoded from the next state so they appear registered with it.
    always_comb begin
        ctl_d     = '0;
        ctl_d.run = (state_d != S_RST) && (state_d != S_HALT);
        case (state_d)
            S_T0: begin
                ctl_d.pc_out = 1'b1; ctl_d.mar_in = 1'b1; ctl_d.inc_pc = 1'b1; ctl_d.pc_in = 1'b1;
            end
            S_T1: begin ctl_d.read = 1'b1; ctl_d.mdr_in = 1'b1; end
            S_T2: begin ctl_d.mdr_out = 1'b1; ctl_d.ir_in = 1'b1; end
            S_T3: case (cls_d)
                CL_ALU, CL_ADDI: begin ctl_d.grb = 1'b1; ctl_d.r_out = 1'b1; ctl_d.y_in = 1'b1; end
                CL_LD, CL_ST:    begin ctl_d.grb = 1'b1; ctl_d.ba_out = 1'b1; ctl_d.y_in = 1'b1; end
                CL_BR:  begin ctl_d.gra = 1'b1; ctl_d.r_out = 1'b1; ctl_d.con_in = 1'b1; end
                CL_JR:  begin ctl_d.gra = 1'b1; ctl_d.r_out = 1'b1; ctl_d.pc_in = 1'b1; end
                CL_JAL: begin ctl_d.pc_out = 1'b1; ctl_d.zlow_in = 1'b1; end
                CL_IN:  begin ctl_d.in_port_out = 1'b1; ctl_d.gra = 1'b1; ctl_d.r_in = 1'b1; end
                CL_OUT: begin ctl_d.gra = 1'b1; ctl_d.r_out = 1'b1; ctl_d.out_port_in = 1'b1; end
                default: ;
            endcase
            S_T4: case (cls_d)
                CL_ALU: begin
                    ctl_d.grc = 1'b1; ctl_d.r_out = 1'b1; ctl_d.zlow_in = 1'b1; ctl_d.alu_op = alu_d;
                end
                CL_ADDI, CL_LD, CL_ST: begin
                    ctl_d.c_out = 1'b1; ctl_d.zlow_in = 1'b1; ctl_d.alu_op = alu_d;
                end
                CL_BR:  begin ctl_d.pc_out = 1'b1; ctl_d.y_in = 1'b1; end
                CL_JAL: begin ctl_d.zlow_out = 1'b1; ctl_d.jal_flag = 1'b1; end
                default: ;
            endcase
            S_T5: case (cls_d)
                CL_ALU, CL_ADDI: begin ctl_d.zlow_out = 1'b1; ctl_d.gra = 1'b1; ctl_d.r_in = 1'b1; end
                CL_LD, CL_ST:    begin ctl_d.zlow_out = 1'b1; ctl_d.mar_in = 1'b1; end
                CL_BR:  begin ctl_d.c_out = 1'b1; ctl_d.zlow_in = 1'b1; ctl_d.alu_op = alu_d; end
                CL_JAL: begin ctl_d.gra = 1'b1; ctl_d.r_out = 1'b1; ctl_d.pc_in = 1'b1; end
                default: ;
            endcase
            S_T6: case (cls_d)
                CL_LD: begin ctl_d.read = 1'b1; ctl_d.mdr_in = 1'b1; end
                CL_ST: begin ctl_d.gra = 1'b1; ctl_d.r_out = 1'b1; ctl_d.mdr_in = 1'b1; end
                CL_BR: begin ctl_d.zlow_out = 1'b1; ctl_d.pc_in = CON; end
                default: ;
            endcase
            S_T7: case (cls_d)
                CL_LD: begin ctl_d.mdr_out = 1'b1; ctl_d.gra = 1'b1; ctl_d.r_in = 1'b1; end
                CL_ST: ctl_d.write = 1'b1;
                default: ;
            endcase
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            state_q <= S_RST;
            cls_q   <= CL_NOP;
            alu_q   <= ALU_PASS;
            ctl_q   <= '0;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            alu_q   <= alu_d;
            ctl_q   <= ctl_d;
        end
    end

    assign ctl_o     = clear ? '0 : ctl_q;
    assign Run       = ctl_o.run;
    assign PCout     = ctl_o.pc_out;
    assign PCin      = ctl_o.pc_in;
    assign IncPC     = ctl_o.inc_pc;
    assign MARin     = ctl_o.mar_in;
    assign MDRin     = ctl_o.mdr_in;
    assign MDRout    = ctl_o.mdr_out;
    assign Read      = ctl_o.read;
    assign Write     = ctl_o.write;
    assign IRin      = ctl_o.ir_in;
    assign Yin       = ctl_o.y_in;
    assign Zlowin    = ctl_o.zlow_in;
    assign Zlowout   = ctl_o.zlow_out;
    assign Gra       = ctl_o.gra;
    assign Grb       = ctl_o.grb;
    assign Grc       = ctl_o.grc;
    assign Rin       = ctl_o.r_in;
    assign Rout      = ctl_o.r_out;
    assign BAout     = ctl_o.ba_out;
    assign Cout      = ctl_o.c_out;
    assign CONin     = ctl_o.con_in;
    assign JAL_flag  = ctl_o.jal_flag;
    assign InPortout = ctl_o.in_port_out;
    assign OutPortin = ctl_o.out_port_in;
    assign alu_op    = ctl_o.alu_op;

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: directed scenarios plus random instruction
// streams compared cycle by cycle against a per-opcode strobe-sequence model.
module tb_control_unit;

    logic        clock = 1'b0;
    logic        clear, CON, Stop;
    logic [31:0] IR;
    logic        Run, PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, Write, IRin;
    logic        Yin, Zlowin, Zlowout, Gra, Grb, Grc, Rin, Rout, BAout, Cout, CONin;
    logic        JAL_flag, InPortout, OutPortin;
    logic [3:0]  alu_op;

    control_unit dut (
        .clock(clock), .clear(clear), .IR(IR), .CON(CON), .Stop(Stop), .Run(Run),
        .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .MDRin(MDRin),
        .MDRout(MDRout), .Read(Read), .Write(Write), .IRin(IRin), .Yin(Yin),
        .Zlowin(Zlowin), .Zlowout(Zlowout), .Gra(Gra), .Grb(Grb), .Grc(Grc),
        .Rin(Rin), .Rout(Rout), .BAout(BAout), .Cout(Cout), .CONin(CONin),
        .JAL_flag(JAL_flag), .InPortout(InPortout), .OutPortin(OutPortin), .alu_op(alu_op)
    );

    always #5 clock = ~clock;

    localparam logic [27:0] M_RUN = 28'd1 << 0,  M_PCOUT = 28'd1 << 1,  M_PCIN = 28'd1 << 2;
    localparam logic [27:0] M_INC = 28'd1 << 3,  M_MARIN = 28'd1 << 4,  M_MDRIN = 28'd1 << 5;
    localparam logic [27:0] M_MDROUT = 28'd1 << 6, M_READ = 28'd1 << 7, M_WRITE = 28'd1 << 8;
    localparam logic [27:0] M_IRIN = 28'd1 << 9, M_YIN = 28'd1 << 10, M_ZIN = 28'd1 << 11;
    localparam logic [27:0] M_ZOUT = 28'd1 << 12, M_GRA = 28'd1 << 13, M_GRB = 28'd1 << 14;
    localparam logic [27:0] M_GRC = 28'd1 << 15, M_RIN = 28'd1 << 16, M_ROUT = 28'd1 << 17;
    localparam logic [27:0] M_BAOUT = 28'd1 << 18, M_COUT = 28'd1 << 19, M_CONIN = 28'd1 << 20;
    localparam logic [27:0] M_JAL = 28'd1 << 21, M_INP = 28'd1 << 22, M_OUTP = 28'd1 << 23;
    localparam logic [27:0] A_ADD = 28'd1 << 24;

    int          nchk = 0, nerr = 0, cyc = 0, last_t0 = 0;
    logic [27:0] exp_q[$];
    bit          exp_halt;
    logic [31:0] pc_m, z_m;
    logic [31:0] rf_m[16];

    function automatic logic [27:0] obs();
        return {alu_op, OutPortin, InPortout, JAL_flag, CONin, Cout, BAout, Rout, Rin, Grc,
                Grb, Gra, Zlowout, Zlowin, Yin, IRin, Write, Read, MDRout, MDRin, MARin,
                IncPC, PCin, PCout, Run};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        assert (got === exp) else begin
            nerr++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    // Minimal datapath: applies this cycle's strobes as of the coming edge.
    task automatic dp_step();
        logic [31:0] bus;
        bus = 32'd0;
        if (PCout)            bus = pc_m;
        else if (Zlowout)     bus = z_m;
        else if (Rout && Gra) bus = rf_m[IR[26:23]];
        if (Zlowin && alu_op == 4'd0) z_m = bus;
        if (PCin)             pc_m = IncPC ? pc_m + 32'd1 : bus;
        if (JAL_flag)         rf_m[15] = bus;
        else if (Rin && Gra)  rf_m[IR[26:23]] = bus;
    endtask

    task automatic push(input logic [27:0] m);
        exp_q.push_back(m | M_RUN);
    endtask

    // Expected strobe words, one per cycle from T0 to the last execute step.
    task automatic build(input logic [4:0] op, input logic con);
        exp_q.delete();
        exp_halt = 1'b0;
        push(M_PCOUT | M_MARIN | M_INC | M_PCIN);
        push(M_READ | M_MDRIN);
        push(M_MDROUT | M_IRIN);
        case (op)
            5'd3, 5'd4, 5'd5, 5'd6: begin
                push(M_GRB | M_ROUT | M_YIN);
                push(M_GRC | M_ROUT | M_ZIN | (28'(op - 5'd2) << 24));
                push(M_ZOUT | M_GRA | M_RIN);
            end
            5'd12: begin
                push(M_GRB | M_ROUT | M_YIN);
                push(M_COUT | M_ZIN | A_ADD);
                push(M_ZOUT | M_GRA | M_RIN);
            end
            5'd0, 5'd2: begin
                push(M_GRB | M_BAOUT | M_YIN);
                push(M_COUT | M_ZIN | A_ADD);
                push(M_ZOUT | M_MARIN);
                if (op == 5'd0) begin
                    push(M_READ | M_MDRIN);
                    push(M_MDROUT | M_GRA | M_RIN);
                end else begin
                    push(M_GRA | M_ROUT | M_MDRIN);
                    push(M_WRITE);
                end
            end
            5'd18: begin
                push(M_GRA | M_ROUT | M_CONIN);
                push(M_PCOUT | M_YIN);
                push(M_COUT | M_ZIN | A_ADD);
                push(M_ZOUT | (con ? M_PCIN : 28'd0));
            end
            5'd19: push(M_GRA | M_ROUT | M_PCIN);
            5'd20: begin
                push(M_PCOUT | M_ZIN);
                push(M_ZOUT | M_JAL);
                push(M_GRA | M_ROUT | M_PCIN);
            end
            5'd21: push(M_INP | M_GRA | M_RIN);
            5'd22: push(M_GRA | M_ROUT | M_OUTP);
            5'd27: exp_halt = 1'b1;
            default: push(28'd0);
        endcase
    endtask

    // Called in the cycle before the instruction's T0; checks ncheck cycles (-1 = all).
    task automatic exec(input logic [31:0] ir, input logic con, input int stop_idx,
                        input int ncheck, input string tag, output bit halts);
        int n;
        IR   = ir;
        CON  = con;
        Stop = 1'b0;
        build(ir[31:27], con);
        n = (ncheck < 0) ? exp_q.size() : ncheck;
        for (int i = 0; i < n; i++) begin
            tick();
            if (i == 0) last_t0 = cyc;
            chk($sformatf("%s_s%0d", tag, i), {4'd0, obs()}, {4'd0, exp_q[i]});
            dp_step();
            if (i == stop_idx) Stop = 1'b1;
        end
        halts = exp_halt || (Stop && n == exp_q.size());
    endtask

    task automatic halt_hold(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            tick();
            chk($sformatf("%s_h%0d", tag, i), {4'd0, obs()}, 32'd0);
        end
    endtask

    task automatic recover(input string tag);
        clear = 1'b1;
        tick();
        chk({tag, "_clr"}, {4'd0, obs()}, 32'd0);
        clear = 1'b0;
        Stop  = 1'b0;
        chk({tag, "_rst"}, {4'd0, obs()}, 32'd0);
    endtask

    logic [4:0]  ops[17] = '{5'd0, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd12, 5'd18, 5'd19,
                            5'd20, 5'd21, 5'd22, 5'd26, 5'd27, 5'd31, 5'd1, 5'd7};

    initial begin
        bit          h;
        int          t_add, sidx;
        logic [31:0] r;
        clear = 1'b1; Stop = 1'b0; CON = 1'b0; IR = 32'd0;
        tick(); tick();
        chk("reset_out", {4'd0, obs()}, 32'd0);
        clear = 1'b0;
        chk("rst_idle", {4'd0, obs()}, 32'd0);

        exec(32'h18918000, 1'b0, -1, -1, "add", h);
        t_add = last_t0;
        exec({5'd26, 27'd0}, 1'b0, -1, -1, "nop", h);
        chk("add_f2f", 32'(last_t0 - t_add), 32'd6);

        pc_m = 32'd14; z_m = 32'd0; rf_m[6] = 32'd28; rf_m[15] = 32'd0;
        exec({5'd20, 4'd6, 23'd0}, 1'b0, -1, -1, "jal", h);
        chk("jal_r15", rf_m[15], 32'd15);
        chk("jal_pc", pc_m, 32'd28);

        exec({5'd18, 4'd2, 23'd5}, 1'b0, -1, -1, "br0", h);
        exec({5'd18, 4'd2, 23'd5}, 1'b1, -1, -1, "br1", h);
        exec({5'd31, 27'd0}, 1'b0, -1, -1, "undef", h);
        exec({5'd3, 27'd0}, 1'b0, -1, -1, "after_undef", h);

        exec({5'd0, 27'h1234}, 1'b0, 4, -1, "ld_stop", h);
        chk("ld_stop_halts", 32'(h), 32'd1);
        halt_hold(10, "ld_stop");
        recover("ld_stop");

        exec({5'd0, 27'h55}, 1'b0, -1, 7, "ld_clr", h);
        clear = 1'b1;
        #1;
        chk("clr_read", 32'(Read), 32'd0);
        chk("clr_force", {4'd0, obs()}, 32'd0);
        tick();
        chk("clr_c1", {4'd0, obs()}, 32'd0);
        tick();
        chk("clr_c2", {4'd0, obs()}, 32'd0);
        clear = 1'b0;
        chk("clr_rst", 32'(Run), 32'd0);
        exec({5'd4, 27'h77}, 1'b0, -1, -1, "post_clr", h);

        exec({5'd3, 27'd9}, 1'b0, 5, -1, "stopclr", h);
        clear = 1'b1;
        tick();
        chk("stopclr_c", {4'd0, obs()}, 32'd0);
        clear = 1'b0; Stop = 1'b0;
        exec({5'd21, 27'd3}, 1'b0, -1, -1, "stopclr_next", h);

        exec({5'd27, 27'd0}, 1'b0, -1, -1, "halt", h);
        halt_hold(5, "halt");
        recover("halt");

        for (int k = 0; k < 60; k++) begin
            r = $urandom();
            sidx = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 7)) : -1;
            exec({ops[$urandom_range(0, 16)], r[26:0]}, 1'($urandom_range(0, 1)), sidx, -1,
                 $sformatf("rnd%0d", k), h);
            if (h) begin
                halt_hold(3, $sformatf("rnd%0d", k));
                recover($sformatf("rnd%0d", k));
            end
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
